// File: rtl/mux_scan_pkg.sv
// Shared constants and FSM encoding for the mux scan controller.
package mux_scan_pkg;

  localparam int SCAN_SEL_W   = 2;
  localparam int SCAN_N_CH    = 2 ** SCAN_SEL_W;
  localparam int SCAN_DWELL_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } scan_state_t;

endpackage

// File: rtl/mux_scan_next_ch.sv
// Priority finder: lowest enabled channel strictly above `current`,
// or the lowest enabled channel overall when from_start is set.
module mux_scan_next_ch
  import mux_scan_pkg::*;
#(
  parameter  int SEL_W = SCAN_SEL_W,
  localparam int N_CH  = 2 ** SEL_W
) (
  input  logic [N_CH-1:0]  mask,
  input  logic [SEL_W-1:0] current,
  input  logic             from_start,
  output logic [SEL_W-1:0] next_ch,
  output logic             has_next
);

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    next_ch  = '0;
    has_next = 1'b0;
    // Walk downward so the lowest qualifying channel is the one left standing.
    for (int n = N_CH - 1; n >= 0; n--) begin
      if (mask[n] && (from_start || (n > int'(current)))) begin
        next_ch  = SEL_W'(n);
        has_next = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mux_scan_controller.sv
// Drives a 4:1 mux select, waits a programmable settle time per enabled
// channel, samples the mux output and assembles a parallel capture word.
module mux_scan_controller
  import mux_scan_pkg::*;
#(
  parameter  int SEL_W   = SCAN_SEL_W,
  parameter  int DWELL_W = SCAN_DWELL_W,
  localparam int N_CH    = 2 ** SEL_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [DWELL_W-1:0] dwell,
  input  logic [N_CH-1:0]    mask,
  input  logic               mux_y,
  output logic [SEL_W-1:0]   select,
  output logic               sample_valid,
  output logic [SEL_W-1:0]   sample_ch,
  output logic [N_CH-1:0]    capture,
  output logic               busy,
  output logic               done
);

  scan_state_t        state, state_d;
  logic [SEL_W-1:0]   select_d;
  logic [DWELL_W-1:0] cnt, cnt_d;
  logic [DWELL_W-1:0] dwell_q, dwell_d;
  logic [N_CH-1:0]    mask_q, mask_d;
  logic [N_CH-1:0]    capture_d;

  logic [SEL_W-1:0]   first_ch, next_ch;
  logic               first_valid, has_next;

  // First-channel search runs on the live mask so select is ready on acceptance.
  mux_scan_next_ch #(.SEL_W(SEL_W)) u_first_ch (
    .mask       (mask),
    .current    ('0),
    .from_start (1'b1),
    .next_ch    (first_ch),
    .has_next   (first_valid)
  );

  mux_scan_next_ch #(.SEL_W(SEL_W)) u_next_ch (
    .mask       (mask_q),
    .current    (select),
    .from_start (1'b0),
    .next_ch    (next_ch),
    .has_next   (has_next)
  );

  always_comb begin
    state_d   = state;
    select_d  = select;
    cnt_d     = cnt;
    dwell_d   = dwell_q;
    mask_d    = mask_q;
    capture_d = capture;

    case (state)
      ST_IDLE: begin
        if (start) begin
          capture_d = '0;
          if (first_valid) begin
            dwell_d  = dwell;
            mask_d   = mask;
            select_d = first_ch;
            cnt_d    = dwell;
            state_d  = ST_SETTLE;
          end else begin
            state_d = ST_DONE;
          end
        end
      end

      ST_SETTLE: begin
        if (cnt == '0) state_d = ST_SAMPLE;
        else           cnt_d   = cnt - 1'b1;
      end

      ST_SAMPLE: begin
        capture_d[select] = mux_y;
        if (has_next) begin
          select_d = next_ch;
          cnt_d    = dwell_q;
          state_d  = ST_SETTLE;
        end else begin
          state_d = ST_DONE;
        end
      end

      ST_DONE: state_d = ST_IDLE;

      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its next value from the same pre-edge snapshot.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      select  <= '0;
      cnt     <= '0;
      dwell_q <= '0;
      mask_q  <= '0;
      capture <= '0;
    end else begin
      state   <= state_d;
      select  <= select_d;
      cnt     <= cnt_d;
      dwell_q <= dwell_d;
      mask_q  <= mask_d;
      capture <= capture_d;
    end
  end

  assign sample_valid = (state == ST_SAMPLE);
  assign sample_ch    = select;
  assign busy         = (state != ST_IDLE);
  assign done         = (state == ST_DONE);

endmodule

// File: tb/tb_mux_scan_controller.sv
// Table-driven bench for mux_scan_controller with a behavioural 4:1 mux.
module tb_mux_scan_controller;
  import mux_scan_pkg::*;

  logic                    clk = 1'b0;
  logic                    rst;
  logic                    start;
  logic [SCAN_DWELL_W-1:0] dwell;
  logic [SCAN_N_CH-1:0]    mask;
  logic                    mux_y;
  logic [SCAN_SEL_W-1:0]   select;
  logic                    sample_valid;
  logic [SCAN_SEL_W-1:0]   sample_ch;
  logic [SCAN_N_CH-1:0]    capture;
  logic                    busy;
  logic                    done;

  logic [SCAN_N_CH-1:0]    mux_i;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  assign mux_y = mux_i[select];

  mux_scan_controller dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .dwell        (dwell),
    .mask         (mask),
    .mux_y        (mux_y),
    .select       (select),
    .sample_valid (sample_valid),
    .sample_ch    (sample_ch),
    .capture      (capture),
    .busy         (busy),
    .done         (done)
  );

  typedef struct {
    logic [3:0] mux_i;
    logic [3:0] mask;
    logic [3:0] dwell;
    int         inj_cycle;
    logic [3:0] inj_mask;
    logic [3:0] inj_dwell;
    logic [3:0] exp_cap;
    int         exp_done;
    int         exp_samples;
    logic [1:0] exp_sel;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // One scan from acceptance to the idle cycle after done; optional mid-scan start pulse.
  task automatic run_scan(input int idx, input vec_t v);
    int         done_cyc  = -1;
    int         busy_cnt  = 0;
    int         samp_cnt  = 0;
    int         last_ch   = -1;
    bit         order_ok  = 1'b1;
    logic [3:0] sampled   = '0;
    logic [3:0] cap_done  = 'x;
    @(negedge clk);
    start = 1'b1;
    mask  = v.mask;
    dwell = v.dwell;
    mux_i = v.mux_i;
    @(posedge clk);
    #1 start = 1'b0;
    for (int t = 1; t <= 60 && done_cyc < 0; t++) begin
      @(negedge clk);
      if (busy) busy_cnt++;
      if (sample_valid) begin
        samp_cnt++;
        if (last_ch >= 0 && int'(sample_ch) <= last_ch) order_ok = 1'b0;
        sampled[sample_ch] = 1'b1;
        last_ch = int'(sample_ch);
      end
      if (done) begin
        done_cyc = t;
        cap_done = capture;
      end
      if (v.inj_cycle != 0 && t == v.inj_cycle) begin
        start = 1'b1;
        mask  = v.inj_mask;
        dwell = v.inj_dwell;
      end else if (v.inj_cycle != 0 && t == v.inj_cycle + 1) begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    if (done_cyc < 0) $display("FAIL vec%0d timeout: got no done expected done", idx);
    check($sformatf("vec%0d done_cycle", idx), done_cyc, v.exp_done);
    check($sformatf("vec%0d busy_cycles", idx), busy_cnt, v.exp_done);
    check($sformatf("vec%0d sample_count", idx), samp_cnt, v.exp_samples);
    check($sformatf("vec%0d sampled_set", idx), sampled, v.mask);
    check($sformatf("vec%0d sample_order", idx), order_ok, 1);
    check($sformatf("vec%0d capture", idx), cap_done, v.exp_cap);
    @(negedge clk);
    check($sformatf("vec%0d idle_after", idx), busy, 0);
    check($sformatf("vec%0d select_held", idx), select, v.exp_sel);
  endtask

  initial begin
    //              mux_i    mask     dwell inj  inj_mask inj_dw  cap      done smp sel
    vecs[0] = '{4'b1111, 4'b0000, 4'd5,  0, 4'b0000, 4'd0,  4'b0000,  1,  0, 2'd0};
    vecs[1] = '{4'b1010, 4'b1111, 4'd0,  0, 4'b0000, 4'd0,  4'b1010,  9,  4, 2'd3};
    vecs[2] = '{4'b0110, 4'b1010, 4'd3,  0, 4'b0000, 4'd0,  4'b0010, 11,  2, 2'd3};
    vecs[3] = '{4'b0101, 4'b0101, 4'd1,  0, 4'b0000, 4'd0,  4'b0101,  7,  2, 2'd2};
    vecs[4] = '{4'b1001, 4'b0110, 4'd2,  0, 4'b0000, 4'd0,  4'b0000,  9,  2, 2'd2};
    vecs[5] = '{4'b1111, 4'b1000, 4'd15, 0, 4'b0000, 4'd0,  4'b1000, 18,  1, 2'd3};
    vecs[6] = '{4'b1100, 4'b1100, 4'd1,  2, 4'b0011, 4'd0,  4'b1100,  7,  2, 2'd3};
    vecs[7] = '{4'b0011, 4'b0001, 4'd0,  1, 4'b1110, 4'd15, 4'b0001,  3,  1, 2'd0};

    rst   = 1'b1;
    start = 1'b0;
    dwell = '0;
    mask  = '0;
    mux_i = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    check("reset sample_valid", sample_valid, 0);
    check("reset capture", capture, 0);
    check("reset select", select, 0);

    for (int i = 0; i < 8; i++) run_scan(i, vecs[i]);

    // Synchronous reset in the middle of a scan.
    begin
      int late_done = 0;
      int late_busy = 0;
      @(negedge clk);
      start = 1'b1; mask = 4'b1111; dwell = 4'd3; mux_i = 4'b1111;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (7) @(negedge clk);
      check("midscan capture", capture, 4'b0001);
      check("midscan select", select, 1);
      rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("rst_mid busy", busy, 0);
      check("rst_mid select", select, 0);
      check("rst_mid capture", capture, 0);
      check("rst_mid done", done, 0);
      check("rst_mid sample_valid", sample_valid, 0);
      repeat (5) begin
        @(negedge clk);
        if (done) late_done++;
        if (busy) late_busy++;
      end
      check("rst_mid no_late_done", late_done, 0);
      check("rst_mid stays_idle", late_busy, 0);
    end

    // Mux inputs change every cycle; model captures what is on mux_y at each sample.
    begin
      logic [3:0] model_cap = '0;
      int         exp_ch    = 0;
      int         done_cyc  = -1;
      @(negedge clk);
      start = 1'b1; mask = 4'b1111; dwell = 4'd2; mux_i = 4'd0;
      for (int k = 0; k < 40 && done_cyc < 0; k++) begin
        @(posedge clk);
        #1;
        if (k == 0) start = 1'b0;
        mux_i = mux_i + 4'd1;
        @(negedge clk);
        if (sample_valid) begin
          check($sformatf("toggle ch%0d sample_ch", exp_ch), sample_ch, exp_ch);
          check($sformatf("toggle ch%0d sample_cycle", exp_ch), k + 1, (exp_ch + 1) * 4);
          if (exp_ch < 4) model_cap[exp_ch] = mux_i[exp_ch];
          exp_ch++;
        end
        if (done) done_cyc = k + 1;
      end
      check("toggle sample_count", exp_ch, 4);
      check("toggle done_cycle", done_cyc, 17);
      check("toggle capture", capture, model_cap);
      @(negedge clk);
    end

    // Start held high through DONE: one idle cycle, then a fresh scan.
    @(negedge clk);
    start = 1'b1; mask = 4'b0001; dwell = 4'd0; mux_i = 4'b0001;
    @(posedge clk);
    repeat (3) @(negedge clk);
    check("held first_done", done, 1);
    @(negedge clk);
    check("held idle_gap", busy, 0);
    @(negedge clk);
    check("held restarted", busy, 1);
    start = 1'b0;
    repeat (2) @(negedge clk);
    check("held second_done", done, 1);
    check("held capture", capture, 4'b0001);
    @(negedge clk);
    check("held final_idle", busy, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
